// File: rtl/sample_packer.sv
// sample_packer: quantizes NCH complex 8-bit I/Q channels to 1/2/4/8 bits per
// component and packs the enabled channels into OUT_W-bit words, MSB = oldest.
// Ports:
//   clk, reset        sample clock, async active-high reset
//   cfg_load          strobe latching cfg_mode/cfg_mask/cfg_thresh, clears accumulator
//   cfg_mode          bits per component: 0=1b 1=2b 2=4b 3=8b
//   cfg_mask          channel enables
//   cfg_thresh        magnitude threshold for 2-bit mode
//   in_valid/in_data  one sample of all channels, ch k at [16k+15:16k], I high byte
//   out_data/out_valid/out_ready  packed word handshake
//   overflow_count    saturating count of words dropped under backpressure

// Per-channel quantizer: returns the channel's 2*b bits left-aligned in 16 bits.
module sample_packer_lane (
  input  logic [1:0]  mode,
  input  logic [7:0]  thresh,
  input  logic [15:0] iq,
  output logic [15:0] bits
);
  function automatic logic [7:0] quant(input logic [7:0] x, input logic [1:0] m,
                                       input logic [7:0] th);
    logic [7:0] mag;
    // -128 has no positive counterpart; saturate to 127
    mag = x[7] ? ((x == 8'h80) ? 8'd127 : (~x + 8'd1)) : x;
    case (m)
      2'd0:    quant = {x[7], 7'b0};
      2'd1:    quant = {x[7], (mag >= th), 6'b0};
      2'd2:    quant = {x[7:4], 4'b0};
      default: quant = x;
    endcase
  endfunction

  logic [7:0] qi, qq;
  logic [3:0] bw;

  always_comb begin
    bw   = 4'd1 << mode;
    qi   = quant(iq[15:8], mode, thresh);
    qq   = quant(iq[7:0], mode, thresh);
    bits = {qi, 8'b0} | ({qq, 8'b0} >> bw);
  end
endmodule

module sample_packer #(
  parameter int NCH   = 4,
  parameter int OUT_W = 64,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [1:0]         cfg_mode,
  input  logic [NCH-1:0]     cfg_mask,
  input  logic [7:0]         cfg_thresh,
  input  logic               in_valid,
  input  logic [16*NCH-1:0]  in_data,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   overflow_count
);
  localparam int IN_W  = 16*NCH;
  localparam int ACC_W = OUT_W + IN_W;
  localparam int NW    = $clog2(IN_W + 1);
  localparam int FW    = $clog2(ACC_W + 1);

  typedef struct packed {
    logic [1:0]     mode;
    logic [NCH-1:0] mask;
    logic [7:0]     thresh;
  } cfg_t;

  cfg_t                     cfg_q;
  logic [NCH-1:0][15:0]     lane_bits;
  logic [IN_W-1:0]          new_bits;
  logic [NW-1:0]            new_cnt;
  logic [ACC_W-1:0]         acc_q, merged;
  logic [FW-1:0]            fill_q, total;
  logic                     word_done, word_ok, load_ok;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    sample_packer_lane u_lane (
      .mode  (cfg_q.mode),
      .thresh(cfg_q.thresh),
      .iq    (in_data[16*k +: 16]),
      .bits  (lane_bits[k])
    );
  end

  // Compact enabled channels, ascending, into a left-aligned bit run.
  always_comb begin
    logic [IN_W-1:0] lane_ext;
    logic [3:0]      bw;
    new_bits = '0;
    new_cnt  = '0;
    lane_ext = '0;
    bw       = 4'd1 << cfg_q.mode;
    for (int k = 0; k < NCH; k++) begin
      if (cfg_q.mask[k]) begin
        lane_ext = IN_W'(lane_bits[k]) << (IN_W - 16);
        new_bits = new_bits | (lane_ext >> new_cnt);
        new_cnt  = new_cnt + NW'({bw, 1'b0});
      end
    end
  end

  // Append behind the current fill; bits below the fill are always zero.
  always_comb begin
    merged    = acc_q | ((ACC_W'(new_bits) << OUT_W) >> fill_q);
    total     = fill_q + FW'(new_cnt);
    word_done = (total >= FW'(OUT_W));
    word_ok   = in_valid && !cfg_load && word_done;
    load_ok   = !out_valid || out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q  <= '{mode: 2'd1, mask: '1, thresh: 8'd32};
      acc_q  <= '0;
      fill_q <= '0;
    end else if (cfg_load) begin
      cfg_q  <= '{mode: cfg_mode, mask: cfg_mask, thresh: cfg_thresh};
      acc_q  <= '0;
      fill_q <= '0;
    end else if (in_valid) begin
      if (word_done) begin
        acc_q  <= merged << OUT_W;
        fill_q <= total - FW'(OUT_W);
      end else begin
        acc_q  <= merged;
        fill_q <= total;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data       <= '0;
      out_valid      <= 1'b0;
      overflow_count <= '0;
    end else if (word_ok && load_ok) begin
      out_data  <= merged[ACC_W-1 -: OUT_W];
      out_valid <= 1'b1;
    end else begin
      if (word_ok && (overflow_count != '1))
        overflow_count <= overflow_count + 1'b1;
      if (out_valid && out_ready)
        out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sample_packer.sv
module tb_sample_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_load = 1'b0;
  logic [1:0]  cfg_mode = 2'd1;
  logic [3:0]  cfg_mask = 4'hF;
  logic [7:0]  cfg_thresh = 8'd32;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [63:0] out_data, out_data2;
  logic        out_valid, out_valid2;
  logic        out_ready = 1'b0;
  logic        ready2 = 1'b0;
  logic [15:0] ovf;
  logic [1:0]  ovf2;

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  sample_packer #(.NCH(4), .OUT_W(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
    .cfg_mask(cfg_mask), .cfg_thresh(cfg_thresh), .in_valid(in_valid),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overflow_count(ovf)
  );

  // Never-ready twin with a 2-bit counter for saturation.
  sample_packer #(.NCH(4), .OUT_W(64), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
    .cfg_mask(cfg_mask), .cfg_thresh(cfg_thresh), .in_valid(in_valid),
    .in_data(in_data), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(ready2), .overflow_count(ovf2)
  );

  always @(negedge clk) if (out_valid && out_ready) q.push_back(out_data);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] qget(input int i);
    if (i < q.size()) return q[i];
    return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  task automatic step(input logic v, input logic [63:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [3:0] mk, input logic [7:0] th,
                     input logic v, input logic [63:0] d);
    cfg_load = 1'b1; cfg_mode = m; cfg_mask = mk; cfg_thresh = th;
    step(v, d);
    cfg_load = 1'b0;
  endtask

  localparam logic [63:0] PA = {4{16'h649C}};  // 01 11 -> 0x7 per channel
  localparam logic [63:0] PB = {4{16'h9C64}};  // 11 01 -> 0xD
  localparam logic [63:0] PC = {4{16'h107F}};  // 00 01 -> 0x1
  localparam logic [63:0] PF = {16'h5555, 16'hE0F0, 16'hC0D0, 16'hA0B0};
  localparam logic [63:0] PG = {16'hFF81, 16'h7F01, 16'h8000, 16'h0080};
  localparam logic [63:0] PH = {16'h7E80, 16'h8200, 16'h7F81, 16'h807E};

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // default config, first word and its latency
    repeat (3) step(1'b1, PA);
    chk("lat_pre", 64'(out_valid), 64'd0);
    step(1'b1, PA);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("dflt_word", out_data, 64'h7777777777777777);

    // backpressure: second word dropped, held word stable
    repeat (4) step(1'b1, PB);
    chk("bp_hold", out_data, 64'h7777777777777777);
    chk("bp_ovf", 64'(ovf), 64'd1);
    chk("bp_valid", 64'(out_valid), 64'd1);
    repeat (3) step(1'b1, PC);
    out_ready = 1'b1;
    step(1'b1, PC);
    out_ready = 1'b0;
    chk("bp_reload", out_data, 64'h1111111111111111);
    chk("bp_noinc", 64'(ovf), 64'd1);
    chk("bp_valid2", 64'(out_valid), 64'd1);
    chk("sat_mid", 64'(ovf2), 64'd2);
    out_ready = 1'b1;
    step(1'b0, '0);
    chk("drop_valid", 64'(out_valid), 64'd0);

    // saturation of the 2-bit counter after six drops
    q.delete();
    repeat (16) step(1'b1, PA);
    step(1'b0, '0);
    chk("sat_ovf2", 64'(ovf2), 64'd3);
    chk("sat_ovf1", 64'(ovf), 64'd1);
    chk("sat_words", 64'(q.size()), 64'd4);

    // 8-bit mode, channel 0 only
    cfg(2'd3, 4'b0001, 8'd32, 1'b0, '0);
    q.delete();
    repeat (4) step(1'b1, {48'hFFFF_FFFF_FFFF, 16'h1234});
    step(1'b0, '0);
    chk("m8_n", 64'(q.size()), 64'd1);
    chk("m8_word", qget(0), 64'h1234123412341234);

    // 4-bit mode, three channels, word boundaries mid-sample
    cfg(2'd2, 4'b0111, 8'd32, 1'b0, '0);
    q.delete();
    repeat (8) step(1'b1, PF);
    step(1'b0, '0);
    repeat (3) step(1'b1, PF);
    step(1'b0, '0);
    chk("m4_n", 64'(q.size()), 64'd4);
    chk("m4_w0", qget(0), 64'hABCDEFABCDEFABCD);
    chk("m4_w1", qget(1), 64'hEFABCDEFABCDEFAB);
    chk("m4_w2", qget(2), 64'hCDEFABCDEFABCDEF);
    chk("m4_fill0", qget(3), 64'hABCDEFABCDEFABCD);

    // 2-bit corners
    cfg(2'd1, 4'hF, 8'd0, 1'b0, '0);
    q.delete();
    repeat (4) step(1'b1, PG);
    step(1'b0, '0);
    chk("th0_word", qget(0), 64'h7D5F7D5F7D5F7D5F);
    cfg(2'd1, 4'hF, 8'd127, 1'b0, '0);
    q.delete();
    repeat (4) step(1'b1, PH);
    step(1'b0, '0);
    chk("th127_word", qget(0), 64'hC783C783C783C783);

    // cfg_load clears partial bits and swallows a same-cycle sample
    cfg(2'd1, 4'hF, 8'd32, 1'b0, '0);
    q.delete();
    repeat (2) step(1'b1, PA);
    cfg(2'd1, 4'hF, 8'd32, 1'b1, PA);
    repeat (4) step(1'b1, PB);
    step(1'b0, '0);
    chk("cfg_n", 64'(q.size()), 64'd1);
    chk("cfg_word", qget(0), 64'hDDDDDDDDDDDDDDDD);
    chk("cfg_ovf_kept", 64'(ovf), 64'd1);

    // asynchronous reset mid-word
    out_ready = 1'b0;
    repeat (4) step(1'b1, PA);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    repeat (2) step(1'b1, PA);
    #2 reset = 1'b1;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ovf", 64'(ovf), 64'd0);
    chk("mrst_data", out_data, 64'd0);
    chk("mrst_ovf2", 64'(ovf2), 64'd0);
    #10 reset = 1'b0;
    #10;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
